divider_responder: RTL and testbench
====================================

# divider_responder

Memory-mapped iterative 32-bit integer divider that answers the CPU's data-memory bus: the responder end of the store/load interface driven from the EX stage. Software stores operands, stores a start command, polls status, then loads quotient and remainder. It sits beside the data memory; its read data is OR-combined into the EX-stage memory read path.

## Interface
- `BASE_ADDR`, default 32'h0000_FF00: word address of the register window (16 words; bits [3:0] of the base must be 0).
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `mw` input, 1 bit: write enable from the EX stage; a write occurs on a rising edge with `mw`=1 and the address inside the window.
- `addr` input, 32 bits: word address; selected when `addr[31:4]==BASE_ADDR[31:4]`.
- `wdata` input, 32 bits: store data.
- `rdata` output, 32 bits: combinational read of the selected register; 0 when the address is outside the window.
- `busy` output, 1 bit: division in progress.
- `done_irq` output, 1 bit: one-cycle pulse on completion.

## Operation
- Word offsets (`addr[3:0]`):
  - 0 DIVIDEND (RW)
  - 1 DIVISOR (RW)
  - 2 CTRL/STATUS. Write: bit0 start, bit1 signed. Read: bit0 busy, bit1 done, bit2 dbz, bit3 signed_mode.
  - 3 QUOTIENT (RO)
  - 4 REMAINDER (RO)
  - 5–15: read 0; writes ignored.
- Reset: all registers 0, state IDLE, `busy`=0, `done_irq`=0, `rdata` follows the cleared registers.
- FSM states: IDLE, RUN, FIX.
  - IDLE→RUN: CTRL write with start=1 and DIVISOR≠0. Latch the absolute values (signed mode) or raw values, clear done/dbz, load the 6-bit count to 0.
  - RUN: one restoring step per cycle (shift the remainder in the dividend MSB, trial subtract, set the quotient bit). After the 32nd step, go to FIX.
  - FIX: signed mode negates the quotient if the operand signs differ, and negates the remainder if the dividend is negative. Write QUOTIENT/REMAINDER, set done, pulse `done_irq`, go to IDLE.
- Divide by zero (start with DIVISOR=0): stay in IDLE. On the same edge set QUOTIENT=32'hFFFF_FFFF, REMAINDER=DIVIDEND, dbz=1, done=1, and pulse `done_irq`. `busy` never asserts.
- Signed overflow: 0x8000_0000 / −1 gives QUOTIENT 0x8000_0000 and REMAINDER 0. This falls out of the unsigned core and needs no special case.
- A CTRL write with start=0 clears done and dbz.
- While busy, all writes (operands, CTRL including start) are ignored. Reads are always allowed; QUOTIENT/REMAINDER hold their previous results until FIX.
- Out-of-window `mw` is ignored.

## Timing
- Start written on edge N: `busy`=1 after edge N. RUN occupies edges N+1..N+32; FIX is at edge N+33.
- After edge N+33: `busy`=0, done=1, results valid. `done_irq` is high for the cycle after N+33.
- Throughput: a new start is accepted on edge N+34 at the earliest.
- Reads are zero-latency combinational, so they meet the EX-stage load timing.
- `rst` mid-RUN returns to IDLE immediately and clears results. No partial result is ever visible.

## Structure
- Package `risc_div_pkg` holds:
  - register offset constants
  - CTRL/STATUS bit positions
  - the FSM state enum
  - the 32-step count constant
- Sub-module `restoring_div_step`: combinational single step. Inputs are the partial remainder, the dividend bit and the divisor; outputs are the next remainder and the quotient bit. It is instantiated once, iterated by the FSM.

## Test plan
- Unsigned 100/7: store 100 and 7, then CTRL=1. Expect `busy` for 33 edges, then QUOTIENT=14, REMAINDER=2, status=0x2, and a one-cycle `done_irq`.
- Signed −100/7 with CTRL=3: expect QUOTIENT=0xFFFF_FFF2 and REMAINDER=0xFFFF_FFFE.
- Divide by zero, 5/0: expect done with dbz set one edge after start, QUOTIENT=0xFFFF_FFFF, REMAINDER=5, and `busy` never high.
- Signed 0x8000_0000 / 0xFFFF_FFFF: expect QUOTIENT=0x8000_0000, REMAINDER=0.
- Mid-operation events: write a new DIVIDEND and another start at RUN cycle 10. Expect both ignored and the original result produced. In a second run, assert `rst` at RUN cycle 10: expect `busy`=0 and all registers 0 immediately.
- Address decode: read offset 7 and an out-of-window address; expect `rdata`=0 for both. Confirm an out-of-window store does not change DIVIDEND.

Source files
------------

// File: rtl/risc_div_pkg.sv
// Shared constants and types for the memory-mapped iterative divider.
package risc_div_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned NUM_STEPS = 32;

    // Word offsets within the 16-word register window
    localparam logic [3:0] OFF_DIVIDEND  = 4'd0;
    localparam logic [3:0] OFF_DIVISOR   = 4'd1;
    localparam logic [3:0] OFF_CTRL      = 4'd2;
    localparam logic [3:0] OFF_QUOTIENT  = 4'd3;
    localparam logic [3:0] OFF_REMAINDER = 4'd4;

    // CTRL write bits
    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_SIGNED = 1;

    // STATUS read bits
    localparam int unsigned STAT_BUSY   = 0;
    localparam int unsigned STAT_DONE   = 1;
    localparam int unsigned STAT_DBZ    = 2;
    localparam int unsigned STAT_SIGNED = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division step: shift in a dividend bit, trial subtract, emit quotient bit.
module restoring_div_step
    import risc_div_pkg::*;
(
    input  logic [DATA_W-1:0] rem_in,
    input  logic              dvd_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic              q_bit
);

    logic [DATA_W-1:0] low;

    // The shifted remainder is 33 bits; rem_in[31] set means it exceeds any divisor
    always_comb begin
        low     = {rem_in[DATA_W-2:0], dvd_bit};
        q_bit   = rem_in[DATA_W-1] | (low >= divisor);
        rem_out = q_bit ? (low - divisor) : low;
    end

endmodule

// File: rtl/divider_responder.sv
// Memory-mapped 32-bit iterative divider on the EX-stage data bus.
module divider_responder
    import risc_div_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_FF00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mw,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done_irq
);

    state_t state, next_state;

    logic [DATA_W-1:0] dividend_q, divisor_q, quotient_q, remainder_q;
    logic              done_q, dbz_q, signed_q;
    logic [DATA_W-1:0] work_rem, work_dvd, work_dsr;
    logic [CNT_W-1:0]  cnt;
    logic              neg_quo, neg_rem;

    logic              sel, wr_en, ctrl_wr, start, go, dbz_hit, last_step;
    logic [3:0]        off;
    logic [DATA_W-1:0] step_rem;
    logic              step_q;

    // Bus decode; every write is dropped while a division is in flight
    always_comb begin
        sel       = (addr[31:4] == BASE_ADDR[31:4]);
        off       = addr[3:0];
        wr_en     = mw && sel && (state == S_IDLE);
        ctrl_wr   = wr_en && (off == OFF_CTRL);
        start     = ctrl_wr && wdata[CTRL_START];
        go        = start && (divisor_q != '0);
        dbz_hit   = start && (divisor_q == '0);
        last_step = (cnt == CNT_W'(NUM_STEPS - 1));
    end

    restoring_div_step u_step (
        .rem_in  (work_rem),
        .dvd_bit (work_dvd[DATA_W-1]),
        .divisor (work_dsr),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (go) next_state = S_RUN;
            S_RUN:   if (last_step) next_state = S_FIX;
            S_FIX:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            done_irq <= 1'b0;
        end else begin
            busy     <= (next_state != S_IDLE);
            done_irq <= (state == S_FIX) || dbz_hit;
        end
    end

    // Register file and iteration datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend_q  <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            signed_q    <= 1'b0;
            work_rem    <= '0;
            work_dvd    <= '0;
            work_dsr    <= '0;
            cnt         <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
        end else begin
            if (wr_en && off == OFF_DIVIDEND) dividend_q <= wdata;
            if (wr_en && off == OFF_DIVISOR)  divisor_q  <= wdata;
            if (ctrl_wr) begin
                signed_q <= wdata[CTRL_SIGNED];
                done_q   <= 1'b0;
                dbz_q    <= 1'b0;
            end
            if (dbz_hit) begin
                quotient_q  <= '1;
                remainder_q <= dividend_q;
                done_q      <= 1'b1;
                dbz_q       <= 1'b1;
            end
            if (go) begin
                work_dvd <= (wdata[CTRL_SIGNED] && dividend_q[DATA_W-1]) ? -dividend_q : dividend_q;
                work_dsr <= (wdata[CTRL_SIGNED] && divisor_q[DATA_W-1])  ? -divisor_q  : divisor_q;
                work_rem <= '0;
                cnt      <= '0;
                neg_quo  <= wdata[CTRL_SIGNED] && (dividend_q[DATA_W-1] ^ divisor_q[DATA_W-1]);
                neg_rem  <= wdata[CTRL_SIGNED] && dividend_q[DATA_W-1];
            end
            // Quotient bits shift into the low end of the dividend register
            if (state == S_RUN) begin
                work_rem <= step_rem;
                work_dvd <= {work_dvd[DATA_W-2:0], step_q};
                cnt      <= cnt + CNT_W'(1);
            end
            if (state == S_FIX) begin
                quotient_q  <= neg_quo ? -work_dvd : work_dvd;
                remainder_q <= neg_rem ? -work_rem : work_rem;
                done_q      <= 1'b1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                OFF_DIVIDEND:  rdata = dividend_q;
                OFF_DIVISOR:   rdata = divisor_q;
                OFF_CTRL: begin
                    rdata[STAT_BUSY]   = busy;
                    rdata[STAT_DONE]   = done_q;
                    rdata[STAT_DBZ]    = dbz_q;
                    rdata[STAT_SIGNED] = signed_q;
                end
                OFF_QUOTIENT:  rdata = quotient_q;
                OFF_REMAINDER: rdata = remainder_q;
                default:       rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_responder.sv
// Randomised bench for divider_responder against a transaction-level register/latency model.
module tb_divider_responder;

    localparam logic [31:0] BASE = 32'h0000_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mw = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        busy;
    logic        done_irq;

    int n_checks = 0;
    int n_pass   = 0;

    divider_responder #(.BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .mw       (mw),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .done_irq (done_irq)
    );

    always #5 clk = ~clk;

    // Model: visible registers plus a countdown to when the pending result appears
    logic [31:0] m_dvd = 0, m_dsr = 0, m_q = 0, m_r = 0, p_q = 0, p_r = 0;
    logic        m_done = 0, m_dbz = 0, m_signed = 0, m_irq = 0;
    int          left = 0;

    task automatic compute(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (!sgn) begin
            p_q = a / b;
            p_r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            p_q = 32'h8000_0000;
            p_r = 32'h0;
        end else begin
            p_q = sa / sb;
            p_r = sa % sb;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_dvd = 0; m_dsr = 0; m_q = 0; m_r = 0;
            m_done = 0; m_dbz = 0; m_signed = 0; m_irq = 0; left = 0;
        end else begin
            m_irq = 0;
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    m_q = p_q; m_r = p_r; m_done = 1; m_irq = 1;
                end
            end else if (mw && addr[31:4] == BASE[31:4]) begin
                case (addr[3:0])
                    4'd0: m_dvd = wdata;
                    4'd1: m_dsr = wdata;
                    4'd2: begin
                        m_signed = wdata[1];
                        m_done = 0;
                        m_dbz = 0;
                        if (wdata[0]) begin
                            if (m_dsr == 0) begin
                                m_q = 32'hFFFF_FFFF; m_r = m_dvd;
                                m_done = 1; m_dbz = 1; m_irq = 1;
                            end else begin
                                compute(m_dvd, m_dsr, wdata[1]);
                                left = 33;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [31:0] mread(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'h0;
        case (a[3:0])
            4'd0: return m_dvd;
            4'd1: return m_dsr;
            4'd2: return {28'h0, m_signed, m_dbz, m_done, left > 0};
            4'd3: return m_q;
            4'd4: return m_r;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("cyc_busy", {31'h0, busy}, {31'h0, left > 0});
        check("cyc_irq", {31'h0, done_irq}, {31'h0, m_irq});
        check("cyc_rdata", rdata, mread(addr));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        addr = BASE | {28'h0, off};
        wdata = d;
        mw = 1'b1;
        step();
        mw = 1'b0;
    endtask

    task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        @(negedge clk);
        check(name, rdata, exp);
        step();
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        check("busy_timeout", {31'h0, busy}, 32'h0);
    endtask

    int          cyc;
    logic [31:0] a, b;
    logic        sgn;

    initial begin
        step();
        step();
        rst = 1'b0;
        peek("reset_status", BASE | 32'h2, 32'h0);
        peek("reset_quot", BASE | 32'h3, 32'h0);

        // Unsigned 100/7 with latency and irq pinned by hand
        wr(4'd0, 32'd100);
        wr(4'd1, 32'd7);
        wr(4'd2, 32'h1);
        check("start_busy", {31'h0, busy}, 32'h1);
        wait_idle(cyc);
        check("busy_cycles", cyc, 33);
        check("irq_high", {31'h0, done_irq}, 32'h1);
        step();
        check("irq_pulse_end", {31'h0, done_irq}, 32'h0);
        peek("u_quot", BASE | 32'h3, 32'd14);
        peek("u_rem", BASE | 32'h4, 32'd2);
        peek("u_status", BASE | 32'h2, 32'h2);

        // Signed -100/7
        wr(4'd0, 32'hFFFF_FF9C);
        wr(4'd2, 32'h3);
        wait_idle(cyc);
        peek("s_quot", BASE | 32'h3, 32'hFFFF_FFF2);
        peek("s_rem", BASE | 32'h4, 32'hFFFF_FFFE);
        peek("s_status", BASE | 32'h2, 32'hA);

        // Divide by zero: done in one edge, busy never rises
        wr(4'd0, 32'd5);
        wr(4'd1, 32'd0);
        wr(4'd2, 32'h1);
        check("dbz_busy", {31'h0, busy}, 32'h0);
        check("dbz_irq", {31'h0, done_irq}, 32'h1);
        peek("dbz_status", BASE | 32'h2, 32'h6);
        peek("dbz_quot", BASE | 32'h3, 32'hFFFF_FFFF);
        peek("dbz_rem", BASE | 32'h4, 32'd5);
        wr(4'd2, 32'h0);
        peek("clear_status", BASE | 32'h2, 32'h0);

        // Signed overflow
        wr(4'd0, 32'h8000_0000);
        wr(4'd1, 32'hFFFF_FFFF);
        wr(4'd2, 32'h3);
        wait_idle(cyc);
        peek("ovf_quot", BASE | 32'h3, 32'h8000_0000);
        peek("ovf_rem", BASE | 32'h4, 32'h0);

        // Writes during RUN are ignored
        wr(4'd0, 32'd1000);
        wr(4'd1, 32'd3);
        wr(4'd2, 32'h1);
        repeat (9) step();
        wr(4'd0, 32'd55);
        wr(4'd2, 32'h3);
        wait_idle(cyc);
        peek("mid_quot", BASE | 32'h3, 32'd333);
        peek("mid_rem", BASE | 32'h4, 32'd1);
        peek("mid_dvd", BASE | 32'h0, 32'd1000);

        // Reset mid-RUN clears everything immediately
        wr(4'd2, 32'h1);
        repeat (10) step();
        addr = BASE | 32'h3;
        rst = 1'b1;
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_quot", rdata, 32'h0);
        addr = BASE;
        #1;
        check("rst_dvd", rdata, 32'h0);
        step();
        rst = 1'b0;
        step();

        // Address decode
        wr(4'd0, 32'h1234_5678);
        peek("off7", BASE | 32'h7, 32'h0);
        peek("out_window", 32'h1234_0000, 32'h0);
        addr = 32'h0000_FE00;
        wdata = 32'hDEAD_BEEF;
        mw = 1'b1;
        step();
        mw = 1'b0;
        peek("oow_store", BASE, 32'h1234_5678);

        // Randomised operations
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFF_FFFF;
                3: begin b = $urandom; a = $urandom_range(0, 200); end
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            sgn = 1'($urandom_range(0, 1));
            wr(4'd0, a);
            wr(4'd1, b);
            wr(4'd2, {30'h0, sgn, 1'b1});
            wait_idle(cyc);
            peek("rnd_quot", BASE | 32'h3, m_q);
            peek("rnd_rem", BASE | 32'h4, m_r);
            if ($urandom_range(0, 3) == 0) begin
                wr(4'd2, 32'h0);
                peek("rnd_clear", BASE | 32'h2, 32'h0);
            end
        end

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
